// File: rtl/cpu_register_dump.sv
// +-------------------------------------------------------------------------+
// | cpu_register_dump: walks a register-file address range and streams     |
// | each word over valid/ready with a running 8-bit checksum. Rev 1.0       |
// +-------------------------------------------------------------------------+
`default_nettype none

module cpu_register_dump #(
  parameter int NUMBER_OF_REGISTERS = 32,
  parameter int DATA_WIDTH          = 8,
  localparam int AW = (NUMBER_OF_REGISTERS > 1) ? $clog2(NUMBER_OF_REGISTERS) : 1
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic                         start_in,
  input  logic [AW-1:0]                first_address_in,
  input  logic [AW-1:0]                last_address_in,
  output logic [AW-1:0]                read_register_address_out,
  input  logic signed [DATA_WIDTH-1:0] read_data_in,
  output logic                         dump_valid_out,
  input  logic                         dump_ready_in,
  output logic signed [DATA_WIDTH-1:0] dump_data_out,
  output logic [AW-1:0]                dump_address_out,
  output logic                         dump_last_out,
  output logic                         busy_out,
  output logic                         done_out,
  output logic [DATA_WIDTH-1:0]        checksum_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                  state_q,     state_d;
  logic [AW-1:0]               addr_q,      addr_d;
  logic [AW-1:0]               last_addr_q, last_addr_d;
  logic [AW-1:0]               rd_addr_q,   rd_addr_d;
  logic signed [DATA_WIDTH-1:0] data_q,     data_d;
  logic [AW-1:0]               daddr_q,     daddr_d;
  logic                        dlast_q,     dlast_d;
  logic                        valid_q,     valid_d;
  logic                        done_q,      done_d;
  logic [DATA_WIDTH-1:0]       checksum_q,  checksum_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    rd_addr_d   = rd_addr_q;
    data_d      = data_q;
    daddr_d     = daddr_q;
    dlast_d     = dlast_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    checksum_d  = checksum_q;

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          addr_d      = first_address_in;
          rd_addr_d   = first_address_in;
          last_addr_d = last_address_in;
          checksum_d  = '0;
          if (first_address_in <= last_address_in) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_FETCH: begin
        // Read port is combinational; rd_addr_q already equals addr_q here.
        data_d  = read_data_in;
        daddr_d = addr_q;
        dlast_d = (addr_q == last_addr_q);
        valid_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (dump_ready_in) begin
          checksum_d = checksum_q + $unsigned(data_q);
          valid_d    = 1'b0;
          if (dlast_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            // Never reached past last_addr_q, so the top address cannot wrap.
            addr_d    = addr_q + AW'(1);
            rd_addr_d = addr_q + AW'(1);
            state_d   = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      last_addr_q <= '0;
      rd_addr_q   <= '0;
      data_q      <= '0;
      daddr_q     <= '0;
      dlast_q     <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      rd_addr_q   <= rd_addr_d;
      data_q      <= data_d;
      daddr_q     <= daddr_d;
      dlast_q     <= dlast_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      checksum_q  <= checksum_d;
    end
  end

  assign read_register_address_out = rd_addr_q;
  assign dump_valid_out            = valid_q;
  assign dump_data_out             = data_q;
  assign dump_address_out          = daddr_q;
  assign dump_last_out             = dlast_q & valid_q;
  assign busy_out                  = (state_q != S_IDLE);
  assign done_out                  = done_q;
  assign checksum_out              = checksum_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_register_dump.sv
// +-------------------------------------------------------------------------+
// | tb_cpu_register_dump: table-driven and randomized bench for the dump.   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_cpu_register_dump;

  logic              clk;
  logic              reset_in;
  logic              start_in;
  logic [4:0]        first_address_in;
  logic [4:0]        last_address_in;
  logic [4:0]        read_register_address_out;
  logic signed [7:0] read_data_in;
  logic              dump_valid_out;
  logic              dump_ready_in;
  logic signed [7:0] dump_data_out;
  logic [4:0]        dump_address_out;
  logic              dump_last_out;
  logic              busy_out;
  logic              done_out;
  logic [7:0]        checksum_out;

  logic [7:0] regs [32];
  int n_checks = 0;
  int n_pass   = 0;

  cpu_register_dump #(
    .NUMBER_OF_REGISTERS(32),
    .DATA_WIDTH(8)
  ) dut (
    .clock_in                  (clk),
    .reset_in                  (reset_in),
    .start_in                  (start_in),
    .first_address_in          (first_address_in),
    .last_address_in           (last_address_in),
    .read_register_address_out (read_register_address_out),
    .read_data_in              (read_data_in),
    .dump_valid_out            (dump_valid_out),
    .dump_ready_in             (dump_ready_in),
    .dump_data_out             (dump_data_out),
    .dump_address_out          (dump_address_out),
    .dump_last_out             (dump_last_out),
    .busy_out                  (busy_out),
    .done_out                  (done_out),
    .checksum_out              (checksum_out)
  );

  // Register file model: combinational read.
  assign read_data_in = regs[read_register_address_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] first;
    logic [4:0] last;
    int         rmode;
    bit         spam;
    bit         use_model;
    logic [7:0] exp_ck;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic bit pick_ready(input int rmode, input int c);
    case (rmode)
      0:       return 1'b1;
      1:       return (c % 4 == 0) || (c % 4 == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run_dump(input vec_t v, input string tag);
    logic [4:0] ea[$];
    logic [7:0] ed[$];
    logic [7:0] model_ck;
    logic [7:0] want_ck;
    logic [7:0] h_data;
    logic [4:0] h_addr;
    logic       h_last;
    bit stalled, finished, rdy, any_valid;
    int first_v, done_c, n_done, n_words;

    model_ck = 8'h00;
    if (v.first <= v.last)
      for (int a = int'(v.first); a <= int'(v.last); a++) begin
        ea.push_back(5'(a));
        ed.push_back(regs[a]);
        model_ck = model_ck + regs[a];
      end
    want_ck = v.use_model ? model_ck : v.exp_ck;
    n_words = ea.size();

    @(negedge clk);
    start_in         = 1'b1;
    first_address_in = v.first;
    last_address_in  = v.last;
    dump_ready_in    = pick_ready(v.rmode, 0);
    stalled = 0; finished = 0; any_valid = 0;
    first_v = -1; done_c = -1; n_done = 0;
    h_data = '0; h_addr = '0; h_last = 1'b0;

    for (int c = 1; c <= 400 && !finished; c++) begin
      @(negedge clk);
      if (stalled) begin
        chk($sformatf("%s stall_data", tag), {24'd0, dump_data_out}, {24'd0, h_data});
        chk($sformatf("%s stall_addr", tag), {27'd0, dump_address_out}, {27'd0, h_addr});
        chk($sformatf("%s stall_last", tag), {31'd0, dump_last_out}, {31'd0, h_last});
      end
      stalled = 0;
      if (done_out) begin
        n_done++;
        if (done_c < 0) begin
          done_c = c;
          chk($sformatf("%s checksum", tag), {24'd0, checksum_out}, {24'd0, want_ck});
        end
      end
      if (dump_valid_out) begin
        any_valid = 1;
        if (first_v < 0) first_v = c;
      end
      rdy = pick_ready(v.rmode, c);
      if (dump_valid_out) begin
        if (rdy) begin
          if (ea.size() == 0) begin
            chk($sformatf("%s extra_word", tag), 32'd1, 32'd0);
          end else begin
            chk($sformatf("%s addr", tag), {27'd0, dump_address_out}, {27'd0, ea[0]});
            chk($sformatf("%s data", tag), {24'd0, dump_data_out}, {24'd0, ed[0]});
            chk($sformatf("%s last", tag), {31'd0, dump_last_out}, {31'd0, ea.size() == 1});
            void'(ea.pop_front());
            void'(ed.pop_front());
          end
        end else begin
          stalled = 1;
          h_data = dump_data_out; h_addr = dump_address_out; h_last = dump_last_out;
        end
      end
      if (done_c >= 0 && c >= done_c + 3) finished = 1;
      dump_ready_in = rdy;
      start_in      = (v.spam && done_c < 0) ? 1'(c % 2) : 1'b0;
    end

    start_in = 1'b0;
    chk($sformatf("%s timeout", tag), {31'd0, finished}, 32'd1);
    chk($sformatf("%s missing_words", tag), ea.size(), 32'd0);
    chk($sformatf("%s done_count", tag), n_done, 32'd1);
    chk($sformatf("%s busy_after", tag), {31'd0, busy_out}, 32'd0);
    chk($sformatf("%s checksum_hold", tag), {24'd0, checksum_out}, {24'd0, want_ck});
    if (n_words > 0) begin
      chk($sformatf("%s first_valid_lat", tag), first_v, 32'd2);
    end else begin
      chk($sformatf("%s empty_no_valid", tag), {31'd0, any_valid}, 32'd0);
      chk($sformatf("%s empty_done_lat", tag), done_c, 32'd1);
    end
  endtask

  vec_t table_v[5];
  vec_t rv;

  initial begin
    reset_in = 1'b1; start_in = 1'b0; dump_ready_in = 1'b0;
    first_address_in = '0; last_address_in = '0;
    for (int i = 0; i < 32; i++) regs[i] = 8'(i * 7 + 3);
    regs[0] = 8'h00;
    regs[1] = 8'h11; regs[2] = 8'h22; regs[3] = 8'hF0; regs[4] = 8'h05;
    regs[31] = 8'hFF;

    table_v[0] = '{first: 5'd1,  last: 5'd4,  rmode: 0, spam: 0, use_model: 0, exp_ck: 8'h28};
    table_v[1] = '{first: 5'd1,  last: 5'd4,  rmode: 1, spam: 0, use_model: 0, exp_ck: 8'h28};
    table_v[2] = '{first: 5'd31, last: 5'd31, rmode: 0, spam: 0, use_model: 0, exp_ck: 8'hFF};
    table_v[3] = '{first: 5'd5,  last: 5'd2,  rmode: 0, spam: 0, use_model: 0, exp_ck: 8'h00};
    table_v[4] = '{first: 5'd0,  last: 5'd7,  rmode: 2, spam: 1, use_model: 1, exp_ck: 8'h00};

    repeat (3) @(negedge clk);
    chk("rst valid",    {31'd0, dump_valid_out}, 32'd0);
    chk("rst busy",     {31'd0, busy_out}, 32'd0);
    chk("rst done",     {31'd0, done_out}, 32'd0);
    chk("rst last",     {31'd0, dump_last_out}, 32'd0);
    chk("rst checksum", {24'd0, checksum_out}, 32'd0);
    chk("rst data",     {24'd0, dump_data_out}, 32'd0);
    chk("rst daddr",    {27'd0, dump_address_out}, 32'd0);
    chk("rst raddr",    {27'd0, read_register_address_out}, 32'd0);
    reset_in = 1'b0;

    for (int i = 0; i < 5; i++) run_dump(table_v[i], $sformatf("vec%0d", i));

    // Reset while holding word 2 of a 0..31 dump.
    begin
      bit hit;
      hit = 0;
      @(negedge clk);
      start_in = 1'b1; first_address_in = 5'd0; last_address_in = 5'd31; dump_ready_in = 1'b1;
      for (int c = 1; c <= 50 && !hit; c++) begin
        @(negedge clk);
        start_in = 1'b0;
        if (dump_valid_out && dump_address_out == 5'd2) begin
          hit = 1;
          dump_ready_in = 1'b0;
          reset_in = 1'b1;
        end
      end
      chk("rstmid reached_word2", {31'd0, hit}, 32'd1);
      @(negedge clk);
      reset_in = 1'b0;
      chk("rstmid valid",    {31'd0, dump_valid_out}, 32'd0);
      chk("rstmid busy",     {31'd0, busy_out}, 32'd0);
      chk("rstmid checksum", {24'd0, checksum_out}, 32'd0);
      repeat (3) @(negedge clk);
      chk("rstmid stays_idle", {30'd0, dump_valid_out, busy_out}, 32'd0);
      rv = '{first: 5'd0, last: 5'd1, rmode: 0, spam: 0, use_model: 1, exp_ck: 8'h00};
      run_dump(rv, "after_rst");
    end

    // Randomized ranges, data and backpressure against the queue model.
    for (int k = 0; k < 20; k++) begin
      for (int i = 1; i < 32; i++) regs[i] = 8'($urandom);
      rv.first     = 5'($urandom_range(0, 31));
      rv.last      = (k % 5 == 4) ? 5'($urandom_range(0, 31)) :
                     5'($urandom_range(int'(rv.first), 31));
      rv.rmode     = 2;
      rv.spam      = 1'(k % 2);
      rv.use_model = 1;
      rv.exp_ck    = 8'h00;
      run_dump(rv, $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
